// File: rtl/cpu_defs.sv
// Shared definitions for the five-stage core: stall vectors, the multi-cycle
// sequencer state encoding and the default step-counter width.
package cpu_defs;

    // Default width of the multi-cycle length and step counter.
    localparam int CNT_W_DEF = 6;

    // Stall vectors, bit 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    // Multi-cycle sequencer states.
    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RUN  = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall and multi-cycle sequencing controller. Merges the decode
// load-use stall with multi-cycle execute operations, drives the per-stage
// stall vector, owns the EX step counter and registers the flush pulse.
module pipe_ctrl
    import cpu_defs::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_len,
    input  logic             ex_mc_cancel,
    input  logic             flush_i,
    output logic [5:0]       stall,
    output logic             mc_busy,
    output logic [CNT_W-1:0] mc_step,
    output logic             mc_done,
    output logic             flush_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    mc_state_e        state_r;
    mc_state_e        state_nx_s;
    logic [CNT_W-1:0] step_r;
    logic [CNT_W-1:0] step_nx_s;
    logic [CNT_W-1:0] last_r;      // final RUN step index, i.e. N-1
    logic [CNT_W-1:0] last_nx_s;
    logic [CNT_W-1:0] len_eff_s;   // requested length with 0 promoted to 1
    logic             flush_o_r;
    logic             stall_ex_s;
    logic [5:0]       stall_s;
    logic             mc_busy_s;
    logic             mc_done_s;

    // A zero length behaves exactly like a single-cycle operation.
    always_comb begin
        if (ex_mc_len == CNT_ZERO) begin
            len_eff_s = CNT_ONE;
        end else begin
            len_eff_s = ex_mc_len;
        end
    end

    // Sequencer state, step counter, final-step index and flush pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= MC_IDLE;
            step_r    <= CNT_ZERO;
            last_r    <= CNT_ZERO;
            flush_o_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            step_r    <= step_nx_s;
            last_r    <= last_nx_s;
            flush_o_r <= flush_i;
        end
    end

    // Next-state and counter logic; a flush abandons any operation at once.
    always_comb begin
        state_nx_s = state_r;
        step_nx_s  = step_r;
        last_nx_s  = last_r;
        if (flush_i) begin
            state_nx_s = MC_IDLE;
            step_nx_s  = CNT_ZERO;
        end else begin
            case (state_r)
                MC_IDLE: begin
                    if (ex_mc_start) begin
                        last_nx_s = len_eff_s - CNT_ONE;
                        if (len_eff_s == CNT_ONE) begin
                            state_nx_s = MC_DONE;
                            step_nx_s  = CNT_ZERO;
                        end else begin
                            state_nx_s = MC_RUN;
                            step_nx_s  = CNT_ONE;
                        end
                    end else begin
                        state_nx_s = MC_IDLE;
                        step_nx_s  = CNT_ZERO;
                    end
                end
                MC_RUN: begin
                    // Counter stops at N-1, so it can never wrap.
                    if (ex_mc_cancel || (step_r == last_r)) begin
                        state_nx_s = MC_DONE;
                        step_nx_s  = CNT_ZERO;
                    end else begin
                        state_nx_s = MC_RUN;
                        step_nx_s  = step_r + CNT_ONE;
                    end
                end
                MC_DONE: begin
                    // A start here belongs to an instruction not yet in EX.
                    state_nx_s = MC_IDLE;
                    step_nx_s  = CNT_ZERO;
                end
                default: begin
                    state_nx_s = MC_IDLE;
                    step_nx_s  = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode: stall priority is flush, then EX, then decode hazard.
    always_comb begin
        stall_ex_s = ((state_r == MC_IDLE) && ex_mc_start) || (state_r == MC_RUN);
        mc_busy_s  = (state_r == MC_RUN);
        mc_done_s  = (state_r == MC_DONE) && !flush_i;
        if (flush_i) begin
            stall_s = STALL_NONE;
        end else if (stall_ex_s) begin
            stall_s = STALL_EX;
        end else if (stallreq_id) begin
            stall_s = STALL_ID;
        end else begin
            stall_s = STALL_NONE;
        end
    end

    assign stall   = stall_s;
    assign mc_busy = mc_busy_s;
    assign mc_step = step_r;
    assign mc_done = mc_done_s;
    assign flush_o = flush_o_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan scenarios followed by
// randomized traffic, all checked against a cycle-timestamp reference model.
module tb_pipe_ctrl;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          stallreq_id;
    logic          ex_mc_start;
    logic [CW-1:0] ex_mc_len;
    logic          ex_mc_cancel;
    logic          flush_i;
    logic [5:0]    stall;
    logic          mc_busy;
    logic [CW-1:0] mc_step;
    logic          mc_done;
    logic          flush_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: an operation is described by the cycle it was accepted
    // in (m_s) and the cycle its result is delivered (m_d).
    bit m_active = 1'b0;
    int m_s = 0;
    int m_d = 0;
    bit m_flush_prev = 1'b0;
    int cyc = 0;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_len    (ex_mc_len),
        .ex_mc_cancel (ex_mc_cancel),
        .flush_i      (flush_i),
        .stall        (stall),
        .mc_busy      (mc_busy),
        .mc_step      (mc_step),
        .mc_done      (mc_done),
        .flush_o      (flush_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic do_cycle(input bit id, input bit st, input int len, input bit can, input bit fl);
        bit         in_run;
        bit         in_done;
        bit         idle;
        logic [5:0] e_stall;
        int         e_step;
        stallreq_id  = id;
        ex_mc_start  = st;
        ex_mc_len    = len[CW-1:0];
        ex_mc_cancel = can;
        flush_i      = fl;
        @(negedge clk);
        in_run  = m_active && (cyc > m_s) && (cyc < m_d);
        in_done = m_active && (cyc == m_d);
        idle    = !in_run && !in_done;
        if (fl)                      e_stall = 6'b000000;
        else if ((idle && st) || in_run) e_stall = 6'b001111;
        else if (id)                 e_stall = 6'b000111;
        else                         e_stall = 6'b000000;
        e_step = in_run ? (cyc - m_s) : 0;
        chk("stall",   {26'd0, stall},   {26'd0, e_stall});
        chk("mc_busy", {31'd0, mc_busy}, {31'd0, in_run});
        chk("mc_step", {26'd0, mc_step}, e_step);
        chk("mc_done", {31'd0, mc_done}, {31'd0, (in_done && !fl)});
        chk("flush_o", {31'd0, flush_o}, {31'd0, m_flush_prev});
        @(posedge clk);
        if (fl) begin
            m_active = 1'b0;
        end else if (idle && st) begin
            m_active = 1'b1;
            m_s      = cyc;
            m_d      = cyc + ((len == 0) ? 1 : len);
        end else if (in_run && can) begin
            m_d = cyc + 1;
        end else if (in_done) begin
            m_active = 1'b0;
        end
        m_flush_prev = fl;
        cyc++;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Pull reset low mid-cycle and confirm outputs clear without a clock edge.
    task automatic async_reset();
        stallreq_id  = 1'b0;
        ex_mc_start  = 1'b0;
        ex_mc_len    = '0;
        ex_mc_cancel = 1'b0;
        flush_i      = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_stall", {26'd0, stall},   32'd0);
        chk("rst_busy",  {31'd0, mc_busy}, 32'd0);
        chk("rst_step",  {26'd0, mc_step}, 32'd0);
        chk("rst_done",  {31'd0, mc_done}, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        m_active     = 1'b0;
        m_flush_prev = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        stallreq_id  = 1'b0;
        ex_mc_start  = 1'b0;
        ex_mc_len    = '0;
        ex_mc_cancel = 1'b0;
        flush_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_stall", {26'd0, stall},   32'd0);
        chk("init_busy",  {31'd0, mc_busy}, 32'd0);
        chk("init_done",  {31'd0, mc_done}, 32'd0);
        chk("init_flush", {31'd0, flush_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Load-use hazard for a single cycle.
        do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle_cycles(2);

        // madd: length 1, and length 0 promoted to 1.
        do_cycle(1'b0, 1'b1, 1, 1'b0, 1'b0);
        idle_cycles(2);
        do_cycle(1'b0, 1'b1, 0, 1'b0, 1'b0);
        idle_cycles(2);

        // div: length 32 with a decode hazard held throughout.
        do_cycle(1'b1, 1'b1, 32, 1'b0, 1'b0);
        for (int i = 0; i < 33; i++) do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle_cycles(1);

        // Maximum length.
        do_cycle(1'b0, 1'b1, 63, 1'b0, 1'b0);
        idle_cycles(64);

        // Cancel at step 5, then a start in DONE that must be ignored.
        do_cycle(1'b0, 1'b1, 32, 1'b0, 1'b0);
        idle_cycles(4);
        do_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1, 4, 1'b0, 1'b0);
        idle_cycles(2);

        // Flush at step 10, with a simultaneous cancel; flush wins.
        do_cycle(1'b0, 1'b1, 32, 1'b0, 1'b0);
        idle_cycles(9);
        do_cycle(1'b1, 1'b0, 0, 1'b1, 1'b1);
        idle_cycles(3);

        // Flush landing in DONE suppresses the result.
        do_cycle(1'b0, 1'b1, 2, 1'b0, 1'b0);
        idle_cycles(1);
        do_cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle_cycles(2);

        // Reset at step 3, then a fresh operation.
        do_cycle(1'b0, 1'b1, 32, 1'b0, 1'b0);
        idle_cycles(2);
        chk("pre_rst_step", {26'd0, mc_step}, 32'd3);
        async_reset();
        do_cycle(1'b0, 1'b1, 4, 1'b0, 1'b0);
        idle_cycles(5);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int len;
            r = $urandom_range(0, 9);
            if (r < 7)       len = $urandom_range(0, 6);
            else if (r == 7) len = 32;
            else             len = $urandom_range(0, 63);
            do_cycle(($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 3) == 0),
                     len,
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 31) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall and multi-cycle sequencing controller for the five-stage core. It merges the decode-stage load-use stall request with multi-cycle execute operations (madd/msub, iterative div) and produces the per-stage stall vector consumed by pc_reg and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also owns the step counter that the execute datapath uses to sequence a multi-cycle operation, and it registers the pipeline flush pulse.

## Interface
- `CNT_W`, 6: width of the multi-cycle length and step counter; the maximum length is 2^CNT_W−1.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stallreq_id` in 1: decode-stage hazard request. Level-sensitive and combinational from decode.
- `ex_mc_start` in 1: execute stage begins a multi-cycle operation in this cycle.
- `ex_mc_len` in CNT_W: number of stall cycles N the operation needs. Sampled only when `ex_mc_start` is accepted.
- `ex_mc_cancel` in 1: execute stage ends the operation early, for example divide by zero.
- `flush_i` in 1: exception or redirect flush request.
- `stall` out 6: stall vector. Bit 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.
- `mc_busy` out 1: a multi-cycle operation is in progress (RUN state).
- `mc_step` out CNT_W: current step index, which the EX datapath uses to select its partial operation.
- `mc_done` out 1: result valid this cycle; EX writes its result and the pipeline advances.
- `flush_o` out 1: registered one-cycle flush pulse sent to all pipeline registers.

## Operation
- The controller has three states: IDLE, RUN and DONE.
- **IDLE**
  - An `ex_mc_start` pulse is accepted.
  - A length of 0 is treated as 1.
  - N=1 goes directly to DONE. N≥2 goes to RUN with step set to 1.
  - `mc_step` reads 0 in the start cycle.
- **RUN**
  - The step counter increments every cycle.
  - When step reaches N−1 the next state is DONE.
  - `ex_mc_cancel` moves the controller to DONE on the next cycle, whatever the step count.
  - `ex_mc_start` is ignored in RUN.
- **DONE**
  - `mc_done` is 1.
  - The next state is IDLE unconditionally.
  - `ex_mc_start` is ignored in DONE, because the instruction that follows has not yet reached EX.
- **EX stall request** (combinational): `stall_ex = (IDLE & ex_mc_start) | RUN`.
- **Stall vector** (combinational, priority in this order):
  - `stall_ex` gives 6'b001111.
  - Otherwise `stallreq_id` gives 6'b000111.
  - Otherwise 6'b000000.
- **Flush**
  - `flush_i` overrides everything: the state goes to IDLE, the step to 0, and `stall` is 6'b000000 in the same cycle.
  - `flush_o` is 1 on the following cycle.
  - `flush_i` in DONE suppresses `mc_done` in that cycle.
- `mc_busy` = state is RUN.
- Each counter is CNT_W wide; it never wraps, because it stops at N−1.

## Timing
- **Reset values:** state IDLE, step 0, `stall` 0, `mc_busy` 0, `mc_done` 0, `flush_o` 0. Reset is asynchronous and can occur mid-operation; it abandons the operation without a `mc_done` pulse.
- **Cycle counts:** an operation of length N stalls EX for exactly N cycles (the start cycle plus N−1 RUN cycles). `mc_done` arrives N cycles after the start cycle.
- **Example, madd (N=1):** the start cycle is stalled and the next cycle is DONE, so madd takes two EX cycles in total.
- **Example, div (N=32):** 32 stall cycles, with `mc_done` in cycle 32 counting the start cycle as cycle 0.
- **Outputs:**
  - `stall` is combinational.
  - `mc_done`, `mc_busy` and `mc_step` are decoded from registered state.
  - `flush_o` is a register.
- **Simultaneous events:**
  - `stallreq_id` together with RUN gives the EX vector.
  - `ex_mc_cancel` together with `flush_i`: the flush wins.
  - `ex_mc_cancel` in IDLE or DONE is ignored.

## Structure
- **Shared package `cpu_defs`:**
  - stall constants `STALL_NONE` = 6'b000000, `STALL_ID` = 6'b000111, `STALL_EX` = 6'b001111;
  - the state encoding IDLE/RUN/DONE;
  - `CNT_W` default.
- **Single module, no sub-module.** The counter is too small to justify one.

## Test plan
- **Load-use hazard:** `stallreq_id`=1 for 1 cycle in IDLE → `stall`=000111 in that cycle only; `mc_busy` stays 0.
- **madd:** `ex_mc_start` with len=1 → `stall`=001111 in cycle 0; `mc_done`=1 and `stall`=0 in cycle 1; IDLE in cycle 2.
- **div:** start with len=32 while `stallreq_id` is also held → `stall`=001111 for 32 cycles; `mc_step` counts 0..31; `mc_done` in cycle 32.
- **Cancel:** len=32, `ex_mc_cancel` asserted at step 5 → DONE in the next cycle, `mc_done`=1, then IDLE; a start asserted in DONE is ignored.
- **Flush:** `flush_i` at step 10 of len=32 → `stall`=0 that cycle; `flush_o`=1 the next cycle; state IDLE; no `mc_done`.
- **Reset:** `rst` low at step 3 → all outputs 0 immediately, without waiting for an edge; a start after release behaves as a fresh operation.
